wm8731_i2c_init: RTL and testbench

//  Upstream configuration stage for the audio top: after reset or a start pulse, writes the WM8731

---
 rtl/wm8731_pkg.sv | 45 ++++
 rtl/i2c_bit_engine.sv | 91 +++++++++
 rtl/wm8731_i2c_init.sv | 203 ++++++++++++++++++++
 tb/tb_wm8731_i2c_init.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// WM8731 init: shared types, device address and codec register table.
// Table words are {reg_addr[6:0], data[8:0]}.
package wm8731_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_GAP,
    S_DONE,
    S_ERR
  } i2c_state_t;

  typedef enum logic [2:0] {
    SL_IDLE,
    SL_START,
    SL_DATA,
    SL_ACK,
    SL_STOP
  } slot_t;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;
  localparam int CFG_N = 7;

  localparam logic [15:0] CFG_TABLE [CFG_N] = '{
    16'h1E00,
    16'h0C00,
    16'h0812,
    16'h0A00,
    16'h0E42,
    16'h1019,
    16'h1201
  };

  function automatic logic [15:0] cfg_word(input logic [3:0] idx);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < CFG_N; i++)
      if (idx == 4'(i)) w = CFG_TABLE[i];
    return w;
  endfunction

endpackage

// File: rtl/i2c_bit_engine.sv
// I2C slot timing: four quarters per slot, SCL low,low,high,high.
// Bus outputs are registered, so SCL and SDA both lag the phase by one clk.
module i2c_bit_engine
  import wm8731_pkg::*;
#(
  parameter int CLK_DIV = 30
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  run,
  input  slot_t slot,
  input  logic  bit_val,
  input  logic  sda_in,
  output logic  scl,
  output logic  sda_oe,
  output logic  slot_done,
  output logic  sampled_sda
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    ph_q, ph_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;
  logic          smp_q, smp_d;
  logic          tick;

  always_comb begin
    tick   = (qcnt_q == QW'(CLK_DIV - 1));
    qcnt_d = qcnt_q;
    ph_d   = ph_q;
    smp_d  = smp_q;
    if (!run) begin
      qcnt_d = '0;
      ph_d   = '0;
    end else if (tick) begin
      qcnt_d = '0;
      ph_d   = ph_q + 2'd1;
      // entering quarter 2: SDA has been stable since SCL fell
      if (ph_q == 2'd1) smp_d = sda_in;
    end else begin
      qcnt_d = qcnt_q + 1'b1;
    end

    scl_d = 1'b1;
    oe_d  = 1'b0;
    unique case (slot)
      SL_START: begin
        scl_d = ~ph_q[1];
        oe_d  = 1'b1;
      end
      SL_DATA: begin
        scl_d = ph_q[1];
        oe_d  = ~bit_val;
      end
      SL_ACK: begin
        scl_d = ph_q[1];
      end
      SL_STOP: begin
        scl_d = ph_q[1];
        oe_d  = (ph_q != 2'd3);
      end
      default: begin
        scl_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt_q <= '0;
      ph_q   <= '0;
      scl_q  <= 1'b1;
      oe_q   <= 1'b0;
      smp_q  <= 1'b1;
    end else begin
      qcnt_q <= qcnt_d;
      ph_q   <= ph_d;
      scl_q  <= scl_d;
      oe_q   <= oe_d;
      smp_q  <= smp_d;
    end
  end

  assign scl         = scl_q;
  assign sda_oe      = oe_q;
  assign sampled_sda = smp_q;
  assign slot_done   = run && tick && (ph_q == 2'd3);

endmodule

// File: rtl/wm8731_i2c_init.sv
// WM8731 configuration master: writes the register table over I2C
// after reset or a start pulse, retrying NACKed entries.
module wm8731_i2c_init
  import wm8731_pkg::*;
#(
  parameter int         CLK_DIV   = 30,
  parameter logic [6:0] DEV_ADDR  = WM8731_ADDR,
  parameter int         NUM_REGS  = 7,
  parameter int         MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic I2C_SCLK,
  inout  wire  I2C_SDAT,
  output logic busy,
  output logic done,
  output logic ack_err
);

  localparam int EW = $clog2(NUM_REGS + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  i2c_state_t    state_q, state_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    byte_q, byte_d;
  logic [3:0]    bit_q, bit_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          nack_q, nack_d;
  logic          arm_q, arm_d;

  logic          run;
  slot_t         slot;
  logic          bit_val;
  logic          sda_oe;
  logic          slot_done;
  logic          sampled_sda;
  logic [15:0]   cfg;
  logic [7:0]    cur_byte;

  always_comb begin
    cfg = cfg_word(4'(entry_q));
    unique case (byte_q)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = cfg[15:8];
      default: cur_byte = cfg[7:0];
    endcase
    bit_val = cur_byte[3'd7 - bit_q[2:0]];

    run  = 1'b1;
    slot = SL_IDLE;
    unique case (state_q)
      S_START: slot = SL_START;
      S_BYTE:  slot = SL_DATA;
      S_ACK:   slot = SL_ACK;
      S_STOP:  slot = SL_STOP;
      S_GAP:   slot = SL_IDLE;
      default: run  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    retry_d = retry_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    nack_d  = nack_q;
    arm_d   = arm_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // arm_q makes the first cycle out of reset an accepted start
        if (start || arm_q) begin
          state_d = S_START;
          entry_d = '0;
          retry_d = '0;
          byte_d  = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          nack_d  = 1'b0;
          arm_d   = 1'b0;
        end
      end
      S_START: begin
        if (slot_done) begin
          state_d = S_BYTE;
          byte_d  = '0;
          bit_d   = '0;
        end
      end
      S_BYTE: begin
        if (slot_done) begin
          if (bit_q == 4'd7) begin
            state_d = S_ACK;
            bit_d   = 4'd8;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (slot_done) begin
          if (sampled_sda) begin
            state_d = S_STOP;
            nack_d  = 1'b1;
          end else if (byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BYTE;
            byte_d  = byte_q + 2'd1;
            bit_d   = '0;
          end
        end
      end
      S_STOP: begin
        if (slot_done) state_d = S_GAP;
      end
      S_GAP: begin
        if (slot_done) begin
          nack_d = 1'b0;
          byte_d = '0;
          bit_d  = '0;
          if (nack_q) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_ERR;
              busy_d  = 1'b0;
              err_d   = 1'b1;
            end
          end else begin
            retry_d = '0;
            if (entry_q == EW'(NUM_REGS - 1)) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              entry_d = entry_q + 1'b1;
              state_d = S_START;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      retry_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nack_q  <= 1'b0;
      arm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      retry_q <= retry_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      nack_q  <= nack_d;
      arm_q   <= arm_d;
    end
  end

  i2c_bit_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_bit (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .slot       (slot),
    .bit_val    (bit_val),
    .sda_in     (I2C_SDAT),
    .scl        (I2C_SCLK),
    .sda_oe     (sda_oe),
    .slot_done  (slot_done),
    .sampled_sda(sampled_sda)
  );

  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = err_q;

endmodule

// File: tb/tb_wm8731_i2c_init.sv
// Bench for wm8731_i2c_init: pulled-up SDA, ACKing slave that logs
// each transaction and compares it with the expected write sequence.
module tb_wm8731_i2c_init;

  localparam int CLK_DIV = 4;
  localparam int SLOT    = 4 * CLK_DIV;
  localparam int TXN     = 30 * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic scl, busy, done, ack_err;
  wire  sda_bus;
  logic slv_low = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  wm8731_i2c_init #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .I2C_SCLK(scl),
    .I2C_SDAT(sda_bus),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected transactions: byte count and bytes packed MSB-first.
  int          exp_n[$];
  logic [23:0] exp_w[$];
  logic [23:0] log_w[$];

  function automatic logic [15:0] model_word(input int e);
    int a, d;
    case (e)
      0: begin a = 'h0F; d = 'h000; end
      1: begin a = 'h06; d = 'h000; end
      2: begin a = 'h04; d = 'h012; end
      3: begin a = 'h05; d = 'h000; end
      4: begin a = 'h07; d = 'h042; end
      5: begin a = 'h08; d = 'h019; end
      default: begin a = 'h09; d = 'h001; end
    endcase
    return 16'((a << 9) | d);
  endfunction

  task automatic plan(input int nack_entry, input bit all_nack);
    exp_n.delete();
    exp_w.delete();
    log_w.delete();
    if (all_nack) begin
      repeat (4) begin
        exp_n.push_back(1);
        exp_w.push_back(24'h000034);
      end
    end else begin
      for (int e = 0; e < 7; e++) begin
        if (e == nack_entry) begin
          exp_n.push_back(1);
          exp_w.push_back(24'h000034);
        end
        exp_n.push_back(3);
        exp_w.push_back({8'h34, model_word(e)});
      end
    end
  endtask

  // Slave / protocol monitor
  logic        mon_on = 1'b0;
  logic        nack_all = 1'b0;
  int          nack_at = -1;
  int          starts = 0;
  int          stops = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic       scl_p, sda_p, scl_n, sda_n;
    logic       in_xfer, acking, nak;
    int         bitcnt, nb, last_rise, en;
    logic [7:0] sh;
    logic [23:0] cur, ew;
    scl_p = 1'b1; sda_p = 1'b1;
    in_xfer = 1'b0; acking = 1'b0;
    bitcnt = 0; nb = 0; last_rise = -1;
    sh = '0; cur = '0;
    forever begin
      @(negedge clk);
      scl_n = scl;
      sda_n = (sda_bus !== 1'b0);
      if (rst) begin
        in_xfer = 1'b0;
        acking  = 1'b0;
        slv_low = 1'b0;
        bitcnt  = 0;
      end else if (mon_on) begin
        chk("idle_when_not_busy", int'(busy || (scl_n && sda_n)), 1);
        chk("done_err_exclusive", int'(done && ack_err), 0);
        if (scl_n && scl_p && sda_p && !sda_n) begin
          chk("start_while_idle", int'(in_xfer), 0);
          starts++;
          in_xfer = 1'b1; acking = 1'b0;
          bitcnt = 0; nb = 0; cur = '0; last_rise = -1;
        end else if (scl_n && scl_p && !sda_p && sda_n) begin
          stops++;
          in_xfer = 1'b0;
          log_w.push_back(cur);
          if (exp_w.size() == 0) begin
            chk("txn_unexpected", nb, 0);
          end else begin
            en = exp_n.pop_front();
            ew = exp_w.pop_front();
            chk("txn_len", nb, en);
            chk("txn_bytes", int'(cur), int'(ew));
          end
        end else if (in_xfer && !scl_p && scl_n) begin
          if (last_rise >= 0) chk("scl_period", cyc - last_rise, SLOT);
          last_rise = cyc;
          if (bitcnt < 8) begin
            sh = {sh[6:0], sda_n};
            bitcnt++;
          end
        end else if (in_xfer && scl_p && !scl_n) begin
          if (acking) begin
            slv_low = 1'b0;
            acking  = 1'b0;
            bitcnt  = 0;
          end else if (bitcnt == 8) begin
            nb++;
            cur = {cur[15:0], sh};
            nak = nack_all || ((nb == 1) && ((starts == nack_at) || (sh != 8'h34)));
            slv_low = !nak;
            acking  = 1'b1;
          end
        end
      end
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  task automatic wait_for(input int mode, input int tgt, input int lim, output int n);
    n = 0;
    while (n < lim && !((mode == 0 && done) || (mode == 1 && ack_err) ||
                        (mode == 2 && starts >= tgt))) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda_bus !== 1'b0), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(ack_err), 0);

    // 1: auto-start after reset release
    plan(-1, 1'b0);
    mon_on = 1'b1;
    rst = 1'b0;
    wait_for(0, 0, 7 * TXN + 50, n);
    chk("t1_done", int'(done), 1);
    chk("t1_latency_max", int'(n <= 7 * TXN + 5), 1);
    chk("t1_latency_min", int'(n >= 7 * TXN), 1);
    @(negedge clk);
    chk("t1_busy", int'(busy), 0);
    chk("t1_err", int'(ack_err), 0);
    chk("t1_txns", log_w.size(), 7);
    chk("t1_left", exp_w.size(), 0);
    chk("t1_first", int'(log_w[0]), 24'h341E00);
    chk("t1_fifth", int'(log_w[4]), 24'h340E42);
    chk("t1_last", int'(log_w[6]), 24'h341201);

    // 5: restart after done, with an ignored start during entry 3
    plan(-1, 1'b0);
    base = starts;
    pulse_start();
    chk("t5_done_drop", int'(done), 0);
    chk("t5_busy", int'(busy), 1);
    wait_for(2, base + 4, 5 * TXN, n);
    chk("t5_reach_e3", int'(starts >= base + 4), 1);
    repeat (40) @(negedge clk);
    pulse_start();
    chk("t5_busy_kept", int'(busy), 1);
    wait_for(0, 0, 8 * TXN, n);
    chk("t5_done", int'(done), 1);
    chk("t5_txns", log_w.size(), 7);
    chk("t5_left", exp_w.size(), 0);

    // 3: single NACK on entry 2
    plan(2, 1'b0);
    nack_at = starts + 3;
    pulse_start();
    wait_for(0, 0, 9 * TXN, n);
    chk("t3_done", int'(done), 1);
    chk("t3_err", int'(ack_err), 0);
    chk("t3_txns", log_w.size(), 8);
    chk("t3_left", exp_w.size(), 0);
    chk("t3_nacked", int'(log_w[2]), 24'h000034);
    chk("t3_resent", int'(log_w[3]), 24'h340812);
    nack_at = -1;

    // 4: slave never ACKs
    plan(-1, 1'b1);
    nack_all = 1'b1;
    pulse_start();
    wait_for(1, 0, 4 * TXN, n);
    chk("t4_err", int'(ack_err), 1);
    @(negedge clk);
    chk("t4_done", int'(done), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_scl", int'(scl), 1);
    chk("t4_sda", int'(sda_bus !== 1'b0), 1);
    chk("t4_txns", log_w.size(), 4);
    chk("t4_left", exp_w.size(), 0);
    chk("start_stop_pairs", starts, stops);
    nack_all = 1'b0;

    // 6: reset during a byte of entry 4, then full restart
    plan(-1, 1'b0);
    base = starts;
    pulse_start();
    chk("t6_err_clear", int'(ack_err), 0);
    wait_for(2, base + 5, 6 * TXN, n);
    chk("t6_reach_e4", int'(starts >= base + 5), 1);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_scl", int'(scl), 1);
    chk("t6_sda", int'(sda_bus !== 1'b0), 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    repeat (2) @(negedge clk);
    plan(-1, 1'b0);
    rst = 1'b0;
    wait_for(0, 0, 7 * TXN + 50, n);
    chk("t6_redone", int'(done), 1);
    chk("t6_txns", log_w.size(), 7);
    chk("t6_left", exp_w.size(), 0);
    chk("t6_first", int'(log_w[0]), 24'h341E00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
